cursor_overlay_sequencer: RTL

Sequences the mouse-cursor bitmap ROM (5-bit line index in, 8-bit row pattern out) against the VGA raster. It latches the mouse position once per frame, fetches the cursor row matching the current scanline, and serialises that row into a per-pixel cursor_on flag. The pixel mux uses cursor_on to overlay the arrow on the video output. The block sits between the VGA sync generator, the PS/2 mouse position logic and the cursor ROM.

---
 rtl/cursor_overlay_sequencer_if.sv | 34 +++
 rtl/cursor_overlay_sequencer.sv | 109 ++++++++++
 2 files changed

// File: rtl/cursor_overlay_sequencer_if.sv
// Raster/cursor bus between the VGA timing, mouse position logic, cursor ROM
// and the overlay sequencer.
//   master : raster timing, mouse position and ROM data (drives the sequencer)
//   slave  : the sequencer (drives line_number, cursor_on, busy)
interface cursor_overlay_sequencer_if #(
  parameter int COORD_W = 10,
  parameter int CUR_W   = 8
);
  logic               pix_en;
  logic               frame_start;
  logic               line_start;
  logic               video_on;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic [COORD_W-1:0] mouse_x;
  logic [COORD_W-1:0] mouse_y;
  logic               pos_valid;
  logic [4:0]         line_number;
  logic [CUR_W-1:0]   line_code;
  logic               cursor_on;
  logic               busy;

  modport master (
    output pix_en, frame_start, line_start, video_on, pixel_x, pixel_y,
           mouse_x, mouse_y, pos_valid, line_code,
    input  line_number, cursor_on, busy
  );

  modport slave (
    input  pix_en, frame_start, line_start, video_on, pixel_x, pixel_y,
           mouse_x, mouse_y, pos_valid, line_code,
    output line_number, cursor_on, busy
  );
endinterface

// File: rtl/cursor_overlay_sequencer.sv
// Cursor overlay sequencer: shadows the mouse position per frame, fetches the
// cursor ROM row for the current scanline and serialises it into a per-pixel
// cursor_on flag (one pixel late; the pixel mux delays RGB by one pixel).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of cursor_overlay_sequencer_if
//                (raster timing, mouse position, ROM row in; ROM line index,
//                 cursor_on, busy out)
module cursor_overlay_sequencer #(
  parameter int COORD_W = 10,
  parameter int CUR_W   = 8,
  parameter int CUR_H   = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  cursor_overlay_sequencer_if.slave  bus
);
  localparam int CNT_W = $clog2(CUR_W + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] WAIT_X = 2'd2;
  localparam logic [1:0] DRAW   = 2'd3;

  logic [1:0]         state;
  logic [COORD_W-1:0] pend_x, pend_y;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic [CUR_W-1:0]   shift;
  logic [CNT_W-1:0]   col_cnt;
  logic [4:0]         line_number;
  logic               cursor_on;

  logic [COORD_W-1:0] row;
  logic               row_hit;

  // Cursor row for this scanline; the unsigned subtract wraps when the
  // cursor is below the line, so the explicit >= guard is required.
  always_comb begin
    row     = bus.pixel_y - cur_y;
    row_hit = (bus.pixel_y >= cur_y) && (row < COORD_W'(CUR_H));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pend_x      <= '0;
      pend_y      <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
      shift       <= '0;
      col_cnt     <= '0;
      line_number <= '0;
      cursor_on   <= 1'b0;
    end else begin
      if (bus.pos_valid) begin
        pend_x <= bus.mouse_x;
        pend_y <= bus.mouse_y;
      end
      // Same-cycle pos_valid: cur picks up the old pend value.
      if (bus.frame_start) begin
        cur_x <= pend_x;
        cur_y <= pend_y;
      end

      if (bus.line_start) begin
        cursor_on <= 1'b0;
        if (row_hit) begin
          line_number <= row[4:0];
          state       <= FETCH;
        end else begin
          state       <= IDLE;
        end
      end else begin
        case (state)
          FETCH: begin
            shift   <= bus.line_code;
            col_cnt <= '0;
            state   <= WAIT_X;
          end
          WAIT_X: begin
            if (bus.pix_en && (bus.pixel_x == cur_x)) begin
              cursor_on <= shift[0] & bus.video_on;
              shift     <= shift >> 1;
              col_cnt   <= CNT_W'(1);
              state     <= DRAW;
            end
          end
          DRAW: begin
            if (bus.pix_en) begin
              if (col_cnt == CNT_W'(CUR_W)) begin
                cursor_on <= 1'b0;
                state     <= IDLE;
              end else begin
                cursor_on <= shift[0] & bus.video_on;
                shift     <= shift >> 1;
                col_cnt   <= col_cnt + CNT_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.line_number = line_number;
  assign bus.cursor_on   = cursor_on;
  assign bus.busy        = (state != IDLE);
endmodule
